// File: rtl/id_bypass_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_bypass_scoreboard_pkg
// Brief    : Shared constants and slice helpers for the decode operand unit.
// Revision : 1.0 - initial release
// ============================================================================
package id_bypass_scoreboard_pkg;

  // Architectural register that always reads as zero and is never tracked.
  localparam int unsigned REG_ZERO = 0;

  // Per forwarding entry control bits: valid, writes-GPR, data-final.
  localparam int unsigned FWD_CTRL_W = 3;

  // Low bit index of entry idx inside a flattened bus of width-bit fields.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_bypass_scoreboard_operand_resolve.sv
`default_nettype none
// ============================================================================
// Module   : operand_resolve
// Brief    : Combinational priority mux selecting one source operand from
//            forwarding stages, writeback or the register file.
// Revision : 1.0 - initial release
// ============================================================================
module operand_resolve
  import id_bypass_scoreboard_pkg::*;
#(
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NFWD = 3
) (
  input  logic [AW-1:0]      i_src,
  input  logic               i_pending_nz,
  input  logic [NFWD-1:0]    i_fwd_valid,
  input  logic [NFWD-1:0]    i_fwd_we,
  input  logic [NFWD-1:0]    i_fwd_rdy,
  input  logic [NFWD*AW-1:0] i_fwd_addr,
  input  logic [NFWD*DW-1:0] i_fwd_data,
  input  logic               i_wb_valid,
  input  logic               i_wb_we,
  input  logic [AW-1:0]      i_wb_addr,
  input  logic [DW-1:0]      i_wb_data,
  input  logic [DW-1:0]      i_rf_rdata,
  output logic [DW-1:0]      o_value,
  output logic               o_ready
);

  logic          w_fwd_hit;
  logic          w_fwd_rdy;
  logic [DW-1:0] w_fwd_data;
  logic          w_wb_hit;

  // Lowest-index (youngest) matching forwarding stage wins.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_rdy  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < NFWD; i++) begin
      if (!w_fwd_hit && i_fwd_valid[i] && i_fwd_we[i] &&
          (i_fwd_addr[slice_lo(i, AW) +: AW] == i_src)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_rdy  = i_fwd_rdy[i];
        w_fwd_data = i_fwd_data[slice_lo(i, AW*0 + DW) * 0 + slice_lo(i, DW) +: DW];
      end
    end
  end

  assign w_wb_hit = i_wb_valid && i_wb_we && (i_wb_addr == i_src);

  // Zero register, then forwarding, then writeback, then RF gated by the scoreboard.
  always_comb begin
    o_value = i_rf_rdata;
    o_ready = !i_pending_nz;
    if (i_src == AW'(REG_ZERO)) begin
      o_value = '0;
      o_ready = 1'b1;
    end else if (w_fwd_hit) begin
      o_value = w_fwd_data;
      o_ready = w_fwd_rdy;
    end else if (w_wb_hit) begin
      o_value = i_wb_data;
      o_ready = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_bypass_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : id_bypass_scoreboard
// Brief    : Decode slot with valid/allowin handshake, operand bypass from
//            NFWD stages plus writeback, and a per-register pending-write
//            scoreboard that stalls until all read sources are available.
// Revision : 1.0 - initial release
// ============================================================================
module id_bypass_scoreboard
  import id_bypass_scoreboard_pkg::*;
#(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NFWD = 3,
  parameter int CNTW = 2,
  parameter int PW   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_flush,
  input  logic               i_in_valid,
  output logic               o_in_allowin,
  input  logic [PW-1:0]      i_in_payload,
  input  logic [AW-1:0]      i_in_rs,
  input  logic [AW-1:0]      i_in_rt,
  input  logic               i_in_rs_re,
  input  logic               i_in_rt_re,
  input  logic [AW-1:0]      i_in_dest,
  input  logic               i_in_gr_we,
  output logic               o_out_valid,
  input  logic               i_out_allowin,
  output logic [PW-1:0]      o_out_payload,
  output logic [DW-1:0]      o_out_rs_value,
  output logic [DW-1:0]      o_out_rt_value,
  output logic [AW-1:0]      o_out_dest,
  output logic               o_out_gr_we,
  output logic [AW-1:0]      o_rf_raddr1,
  output logic [AW-1:0]      o_rf_raddr2,
  input  logic [DW-1:0]      i_rf_rdata1,
  input  logic [DW-1:0]      i_rf_rdata2,
  input  logic [NFWD-1:0]    i_fwd_valid,
  input  logic [NFWD-1:0]    i_fwd_we,
  input  logic [NFWD-1:0]    i_fwd_rdy,
  input  logic [NFWD*AW-1:0] i_fwd_addr,
  input  logic [NFWD*DW-1:0] i_fwd_data,
  input  logic               i_wb_valid,
  input  logic               i_wb_we,
  input  logic [AW-1:0]      i_wb_addr,
  input  logic [DW-1:0]      i_wb_data
);

  localparam logic [CNTW-1:0] c_cnt_max = '1;

  logic            r_valid;
  logic [PW-1:0]   r_payload;
  logic [AW-1:0]   r_rs;
  logic [AW-1:0]   r_rt;
  logic            r_rs_re;
  logic            r_rt_re;
  logic [AW-1:0]   r_dest;
  logic            r_gr_we;
  logic [CNTW-1:0] r_pending [NREG];

  logic            w_rs_ready;
  logic            w_rt_ready;
  logic            w_dest_sat;
  logic            w_ready_go;
  logic            w_issue;
  logic            w_wb_dec_req;
  logic [NREG-1:0] w_inc_vec;
  logic [NREG-1:0] w_dec_vec;

  operand_resolve #(.AW(AW), .DW(DW), .NFWD(NFWD)) u_rs_resolve (
    .i_src        (r_rs),
    .i_pending_nz (r_pending[r_rs] != '0),
    .i_fwd_valid  (i_fwd_valid),
    .i_fwd_we     (i_fwd_we),
    .i_fwd_rdy    (i_fwd_rdy),
    .i_fwd_addr   (i_fwd_addr),
    .i_fwd_data   (i_fwd_data),
    .i_wb_valid   (i_wb_valid),
    .i_wb_we      (i_wb_we),
    .i_wb_addr    (i_wb_addr),
    .i_wb_data    (i_wb_data),
    .i_rf_rdata   (i_rf_rdata1),
    .o_value      (o_out_rs_value),
    .o_ready      (w_rs_ready)
  );

  operand_resolve #(.AW(AW), .DW(DW), .NFWD(NFWD)) u_rt_resolve (
    .i_src        (r_rt),
    .i_pending_nz (r_pending[r_rt] != '0),
    .i_fwd_valid  (i_fwd_valid),
    .i_fwd_we     (i_fwd_we),
    .i_fwd_rdy    (i_fwd_rdy),
    .i_fwd_addr   (i_fwd_addr),
    .i_fwd_data   (i_fwd_data),
    .i_wb_valid   (i_wb_valid),
    .i_wb_we      (i_wb_we),
    .i_wb_addr    (i_wb_addr),
    .i_wb_data    (i_wb_data),
    .i_rf_rdata   (i_rf_rdata2),
    .o_value      (o_out_rt_value),
    .o_ready      (w_rt_ready)
  );

  // A full counter on our destination must hold the slot so counters never wrap.
  assign w_dest_sat   = r_gr_we && (r_dest != AW'(REG_ZERO)) && (r_pending[r_dest] == c_cnt_max);
  assign w_ready_go   = (!r_rs_re || w_rs_ready) && (!r_rt_re || w_rt_ready) && !w_dest_sat;
  assign o_in_allowin = !r_valid || (w_ready_go && i_out_allowin);
  assign o_out_valid  = r_valid && w_ready_go && !i_flush;
  assign w_issue      = o_out_valid && i_out_allowin;
  assign w_wb_dec_req = i_wb_valid && i_wb_we && (i_wb_addr != AW'(REG_ZERO));

  assign o_out_payload = r_payload;
  assign o_out_dest    = r_dest;
  assign o_out_gr_we   = r_gr_we;
  assign o_rf_raddr1   = r_rs;
  assign o_rf_raddr2   = r_rt;

  // Per-register increment/decrement requests; register zero is never tracked.
  for (genvar g = 0; g < NREG; g++) begin : g_cnt
    assign w_inc_vec[g] = w_issue && r_gr_we && (r_dest == AW'(g)) && (AW'(g) != AW'(REG_ZERO));
    assign w_dec_vec[g] = w_wb_dec_req && (i_wb_addr == AW'(g)) && (r_pending[g] != '0);
  end

  // Slot state: flush kills the slot even while stalled; capture on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rs_re   <= 1'b0;
      r_rt_re   <= 1'b0;
      r_dest    <= '0;
      r_gr_we   <= 1'b0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (o_in_allowin) begin
        r_valid <= i_in_valid;
      end
      if (i_in_valid && o_in_allowin) begin
        r_payload <= i_in_payload;
        r_rs      <= i_in_rs;
        r_rt      <= i_in_rt;
        r_rs_re   <= i_in_rs_re;
        r_rt_re   <= i_in_rt_re;
        r_dest    <= i_in_dest;
        r_gr_we   <= i_in_gr_we;
      end
    end
  end

  // Pending-write counters: +1 on issue, -1 on writeback, net zero on collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) r_pending[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_inc_vec[r] && !w_dec_vec[r]) begin
          r_pending[r] <= r_pending[r] + 1'b1;
        end else if (w_dec_vec[r] && !w_inc_vec[r]) begin
          r_pending[r] <= r_pending[r] - 1'b1;
        end
      end
    end
  end

  // A writeback must always retire a write that was counted at issue.
  always_ff @(posedge clk) begin
    if (!reset && w_wb_dec_req) begin
      assert (r_pending[i_wb_addr] != '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_bypass_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_bypass_scoreboard
// Brief    : Directed and randomized bench for id_bypass_scoreboard with a
//            behavioural slot/scoreboard model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_bypass_scoreboard;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NFWD = 3;
  localparam int CNTW = 2;
  localparam int PW   = 64;
  localparam int CMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_allowin, in_rs_re, in_rt_re, in_gr_we;
  logic [PW-1:0] in_payload, out_payload;
  logic [AW-1:0] in_rs, in_rt, in_dest, out_dest, rf_raddr1, rf_raddr2, wb_addr;
  logic out_valid, out_allowin, out_gr_we, wb_valid, wb_we;
  logic [DW-1:0] out_rs_value, out_rt_value, rf_rdata1, rf_rdata2, wb_data;
  logic [NFWD-1:0] fwd_valid, fwd_we, fwd_rdy;
  logic [NFWD*AW-1:0] fwd_addr_f;
  logic [NFWD*DW-1:0] fwd_data_f;
  logic [AW-1:0] fa [NFWD];
  logic [DW-1:0] fd [NFWD];
  logic [DW-1:0] rf [NREG];

  always #5 clk = ~clk;

  always_comb begin
    fwd_addr_f = '0;
    fwd_data_f = '0;
    for (int i = 0; i < NFWD; i++) begin
      fwd_addr_f[i*AW +: AW] = fa[i];
      fwd_data_f[i*DW +: DW] = fd[i];
    end
  end

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  id_bypass_scoreboard #(.NREG(NREG), .AW(AW), .DW(DW), .NFWD(NFWD), .CNTW(CNTW), .PW(PW)) dut (
    .clk(clk), .reset(reset), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_allowin(in_allowin), .i_in_payload(in_payload),
    .i_in_rs(in_rs), .i_in_rt(in_rt), .i_in_rs_re(in_rs_re), .i_in_rt_re(in_rt_re),
    .i_in_dest(in_dest), .i_in_gr_we(in_gr_we),
    .o_out_valid(out_valid), .i_out_allowin(out_allowin), .o_out_payload(out_payload),
    .o_out_rs_value(out_rs_value), .o_out_rt_value(out_rt_value),
    .o_out_dest(out_dest), .o_out_gr_we(out_gr_we),
    .o_rf_raddr1(rf_raddr1), .o_rf_raddr2(rf_raddr2),
    .i_rf_rdata1(rf_rdata1), .i_rf_rdata2(rf_rdata2),
    .i_fwd_valid(fwd_valid), .i_fwd_we(fwd_we), .i_fwd_rdy(fwd_rdy),
    .i_fwd_addr(fwd_addr_f), .i_fwd_data(fwd_data_f),
    .i_wb_valid(wb_valid), .i_wb_we(wb_we), .i_wb_addr(wb_addr), .i_wb_data(wb_data)
  );

  // Behavioural model state
  bit            m_valid, m_rs_re, m_rt_re, m_gr_we;
  logic [AW-1:0] m_rs, m_rt, m_dest;
  logic [PW-1:0] m_payload;
  int            m_pend [NREG];
  bit            e_ev, e_ea;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_valid = 0; m_rs_re = 0; m_rt_re = 0; m_gr_we = 0;
    m_rs = '0; m_rt = '0; m_dest = '0; m_payload = '0;
    for (int r = 0; r < NREG; r++) m_pend[r] = 0;
  endtask

  // Operand rule: zero reg, first matching fwd, writeback, then RF gated by pending.
  function automatic logic [DW-1:0] resolve(input logic [AW-1:0] s, output bit rdy);
    logic [DW-1:0] v;
    bit found;
    found = 0;
    v = rf[s];
    rdy = (m_pend[s] == 0);
    for (int i = 0; i < NFWD; i++) begin
      if (!found && fwd_valid[i] && fwd_we[i] && fa[i] == s) begin
        found = 1; v = fd[i]; rdy = fwd_rdy[i];
      end
    end
    if (!found && wb_valid && wb_we && wb_addr == s) begin
      v = wb_data; rdy = 1;
    end
    if (s == 0) begin
      v = '0; rdy = 1;
    end
    return v;
  endfunction

  task automatic settle();
    bit rsr, rtr, rg;
    logic [DW-1:0] rsv, rtv;
    #4;
    rsv = resolve(m_rs, rsr);
    rtv = resolve(m_rt, rtr);
    rg = (!m_rs_re || rsr) && (!m_rt_re || rtr) &&
         !(m_gr_we && m_dest != 0 && m_pend[m_dest] == CMAX);
    e_ev = m_valid && rg && !flush;
    e_ea = !m_valid || (rg && out_allowin);
    chk("out_valid", {63'd0, out_valid}, {63'd0, e_ev});
    chk("in_allowin", {63'd0, in_allowin}, {63'd0, e_ea});
    chk("out_payload", out_payload, m_payload);
    chk("out_dest", {59'd0, out_dest}, {59'd0, m_dest});
    chk("out_gr_we", {63'd0, out_gr_we}, {63'd0, m_gr_we});
    if (m_valid) begin
      chk("rf_raddr1", {59'd0, rf_raddr1}, {59'd0, m_rs});
      chk("rf_raddr2", {59'd0, rf_raddr2}, {59'd0, m_rt});
    end
    if (e_ev) begin
      chk("out_rs_value", {32'd0, out_rs_value}, {32'd0, rsv});
      chk("out_rt_value", {32'd0, out_rt_value}, {32'd0, rtv});
    end
  endtask

  task automatic advance();
    bit issue, inc, dec, rfw;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    rfw = wb_valid && wb_we && wb_addr != 0;
    wa = wb_addr;
    wd = wb_data;
    if (reset) begin
      model_reset();
    end else begin
      issue = e_ev && out_allowin;
      inc = issue && m_gr_we && m_dest != 0;
      dec = rfw && m_pend[wa] > 0;
      if (inc && !(dec && wa == m_dest)) m_pend[m_dest]++;
      if (dec && !(inc && wa == m_dest)) m_pend[wa]--;
      if (in_valid && e_ea) begin
        m_payload = in_payload; m_rs = in_rs; m_rt = in_rt;
        m_rs_re = in_rs_re; m_rt_re = in_rt_re; m_dest = in_dest; m_gr_we = in_gr_we;
      end
      if (flush) m_valid = 0;
      else if (e_ea) m_valid = in_valid;
    end
    @(posedge clk);
    if (rfw) rf[wa] = wd;
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; in_valid = 0; in_payload = '0; in_rs = '0; in_rt = '0;
    in_rs_re = 0; in_rt_re = 0; in_dest = '0; in_gr_we = 0; out_allowin = 1;
    fwd_valid = '0; fwd_we = '0; fwd_rdy = '0;
    for (int i = 0; i < NFWD; i++) begin fa[i] = '0; fd[i] = '0; end
    wb_valid = 0; wb_we = 0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic slot_in(input logic [PW-1:0] p, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input bit rs_re, input bit rt_re, input logic [AW-1:0] dest, input bit we);
    in_valid = 1; in_payload = p; in_rs = rs; in_rt = rt;
    in_rs_re = rs_re; in_rt_re = rt_re; in_dest = dest; in_gr_we = we;
  endtask

  task automatic set_fwd(input int i, input logic [AW-1:0] a, input bit rdy, input logic [DW-1:0] d);
    fwd_valid[i] = 1; fwd_we[i] = 1; fa[i] = a; fwd_rdy[i] = rdy; fd[i] = d;
  endtask

  task automatic set_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = 1; wb_we = 1; wb_addr = a; wb_data = d;
  endtask

  task automatic randomize_inputs();
    int q[$];
    clear_inputs();
    reset = ($urandom_range(0, 399) == 0);
    flush = ($urandom_range(0, 99) < 3);
    out_allowin = ($urandom_range(0, 99) < 80);
    if ($urandom_range(0, 99) < 70)
      slot_in({$urandom, $urandom}, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              AW'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
    for (int i = 0; i < NFWD; i++) begin
      fwd_valid[i] = ($urandom_range(0, 99) < 40);
      fwd_we[i] = ($urandom_range(0, 99) < 80);
      fwd_rdy[i] = ($urandom_range(0, 99) < 60);
      fa[i] = AW'($urandom_range(0, 7));
      fd[i] = $urandom;
    end
    for (int r = 1; r < NREG; r++) if (m_pend[r] > 0) q.push_back(r);
    if (q.size() > 0 && $urandom_range(0, 99) < 45)
      set_wb(AW'(q[$urandom_range(0, q.size() - 1)]), $urandom);
    else if ($urandom_range(0, 99) < 10) begin
      wb_valid = 1; wb_we = 0; wb_addr = AW'($urandom_range(0, 7)); wb_data = $urandom;
    end
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) rf[r] = 32'h1000_0000 + r;
    rf[0] = '0;
    clear_inputs();
    model_reset();
    reset = 1;
    @(posedge clk); @(posedge clk); #1;
    settle();
    chk("reset out_valid lit", {63'd0, out_valid}, 64'd0);
    chk("reset allowin lit", {63'd0, in_allowin}, 64'd1);
    advance();
    reset = 0;

    // Back-to-back independent ops, then RAW on reg 1 retired by writeback
    slot_in(64'hA1, 2, 3, 1, 1, 1, 1); settle(); advance();
    slot_in(64'hA2, 5, 6, 1, 1, 4, 1); settle();
    chk("b2b first valid", {63'd0, out_valid}, 64'd1);
    chk("b2b first payload", out_payload, 64'hA1);
    chk("b2b rs rf", {32'd0, out_rs_value}, 64'h1000_0002);
    chk("b2b rt rf", {32'd0, out_rt_value}, 64'h1000_0003);
    advance();
    slot_in(64'hA3, 1, 0, 1, 0, 0, 0); settle();
    chk("b2b second valid", {63'd0, out_valid}, 64'd1);
    chk("b2b second payload", out_payload, 64'hA2);
    advance();
    in_valid = 0; settle();
    chk("raw pending stall", {63'd0, out_valid}, 64'd0);
    advance();
    set_wb(1, 32'hABCD_0001); settle();
    chk("wb same-cycle issue", {63'd0, out_valid}, 64'd1);
    chk("wb bypass value", {32'd0, out_rs_value}, 64'hABCD_0001);
    advance();
    set_wb(4, 32'h4444_4444); slot_in(64'hA4, 1, 4, 1, 1, 0, 0); settle(); advance();
    clear_inputs(); settle();
    chk("pending cleared issue", {63'd0, out_valid}, 64'd1);
    chk("rf after wb rs", {32'd0, out_rs_value}, 64'hABCD_0001);
    chk("rf after wb rt", {32'd0, out_rt_value}, 64'h4444_4444);
    advance();

    // Load-use through forwarding
    slot_in(64'hB1, 5, 0, 1, 0, 0, 0); settle(); advance();
    clear_inputs(); set_fwd(0, 5, 0, 32'h0BAD_0BAD); settle();
    chk("load-use stall", {63'd0, out_valid}, 64'd0);
    advance();
    clear_inputs(); set_fwd(1, 5, 1, 32'hDEAD_BEEF); settle();
    chk("load-use issue", {63'd0, out_valid}, 64'd1);
    chk("load-use value", {32'd0, out_rs_value}, 64'hDEAD_BEEF);
    advance();

    // Forwarding priority and zero register
    clear_inputs(); slot_in(64'hC1, 0, 7, 1, 1, 0, 0); settle(); advance();
    clear_inputs(); set_fwd(0, 7, 1, 32'h11); set_fwd(1, 0, 1, 32'h55); set_fwd(2, 7, 1, 32'h33);
    settle();
    chk("prio valid", {63'd0, out_valid}, 64'd1);
    chk("prio youngest", {32'd0, out_rt_value}, 64'h11);
    chk("reg0 zero", {32'd0, out_rs_value}, 64'h0);
    advance();

    // Multi-cycle producer on reg 9
    clear_inputs(); slot_in(64'hD1, 0, 0, 0, 0, 9, 1); settle(); advance();
    slot_in(64'hD2, 9, 0, 1, 0, 0, 0); settle(); advance();
    clear_inputs(); settle();
    chk("multicycle stall", {63'd0, out_valid}, 64'd0);
    advance();
    set_wb(9, 32'h42); settle();
    chk("multicycle wb issue", {63'd0, out_valid}, 64'd1);
    chk("multicycle wb value", {32'd0, out_rs_value}, 64'h42);
    advance();

    // Saturation on reg 3
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      slot_in(64'hE0 + 64'(k), 0, 0, 0, 0, 3, 1); settle(); advance();
    end
    clear_inputs(); settle();
    chk("sat stall", {63'd0, out_valid}, 64'd0);
    chk("sat allowin", {63'd0, in_allowin}, 64'd0);
    advance();
    set_wb(3, 32'h3333_0001); settle();
    chk("sat stall during wb", {63'd0, out_valid}, 64'd0);
    advance();
    set_wb(3, 32'h3333_0002); settle();
    chk("sat issue with wb", {63'd0, out_valid}, 64'd1);
    advance();
    clear_inputs(); slot_in(64'hE5, 0, 0, 0, 0, 3, 1); settle(); advance();
    clear_inputs(); slot_in(64'hE6, 0, 0, 0, 0, 3, 1); settle();
    chk("collision count kept", {63'd0, out_valid}, 64'd1);
    advance();
    clear_inputs(); settle();
    chk("sat again stall", {63'd0, out_valid}, 64'd0);
    advance();

    // Flush while stalled; counters survive
    flush = 1; slot_in(64'hF1, 0, 0, 0, 0, 0, 0); settle();
    chk("flush out_valid", {63'd0, out_valid}, 64'd0);
    advance();
    clear_inputs(); settle();
    chk("flush slot empty", {63'd0, in_allowin}, 64'd1);
    slot_in(64'hF2, 3, 0, 1, 0, 0, 0);
    advance();
    clear_inputs(); settle();
    chk("flush keeps counters", {63'd0, out_valid}, 64'd0);
    advance();

    // Reset mid-stall clears counters
    reset = 1; settle(); advance(); reset = 0;
    slot_in(64'hF3, 3, 0, 1, 0, 0, 0); settle();
    chk("reset mid-stall out_valid", {63'd0, out_valid}, 64'd0);
    advance();
    clear_inputs(); settle();
    chk("post-reset issue", {63'd0, out_valid}, 64'd1);
    chk("post-reset rf value", {32'd0, out_rs_value}, 64'h3333_0002);
    advance();

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      randomize_inputs();
      settle();
      advance();
    end
    reset = 0;
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
